// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port 0) and a DMA/debug loader (port 1).
// Accesses that are misaligned, out of range or carry a bad funct3 never reach memory; they get an error response instead.
module dmem_arbiter #(
    parameter int MEM_BYTES   = 4096,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [1:0]  req_write_i,
    input  logic [2:0]  req_funct3_0_i,
    input  logic [2:0]  req_funct3_1_i,
    input  logic [31:0] req_addr_0_i,
    input  logic [31:0] req_addr_1_i,
    input  logic [31:0] req_wdata_0_i,
    input  logic [31:0] req_wdata_1_i,
    output logic [1:0]  rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [2:0]  mem_funct3_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    // Size comes from funct3[1:0]; alignment is only meaningful for the legal encodings.
    function automatic logic access_illegal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        logic bad_align;
        if (wr) begin
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        case (f3[1:0])
            2'b01:   bad_align = addr[0];
            2'b10:   bad_align = |addr[1:0];
            default: bad_align = 1'b0;
        endcase
        return bad_f3 | (addr >= MEM_LIMIT) | (CHECK_ALIGN & bad_align);
    endfunction

    logic [1:0]  state_q;
    logic        last_q;
    logic        port_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        gnt_port_s;
    logic        accept_s;
    logic        sel_write_s;
    logic [2:0]  sel_funct3_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    // Grant selection: a lone requester wins, a conflict goes to the port not served last.
    always_comb begin
        gnt_port_s  = 1'b0;
        req_ready_o = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req_valid_i)
                2'b01:   gnt_port_s = 1'b0;
                2'b10:   gnt_port_s = 1'b1;
                2'b11:   gnt_port_s = ~last_q;
                default: gnt_port_s = 1'b0;
            endcase
            if (|req_valid_i) begin
                req_ready_o = gnt_port_s ? 2'b10 : 2'b01;
            end else begin
                req_ready_o = 2'b00;
            end
        end else begin
            req_ready_o = 2'b00;
        end
    end

    assign accept_s     = (state_q == ST_IDLE) && (|req_valid_i);
    assign sel_write_s  = gnt_port_s ? req_write_i[1] : req_write_i[0];
    assign sel_funct3_s = gnt_port_s ? req_funct3_1_i : req_funct3_0_i;
    assign sel_addr_s   = gnt_port_s ? req_addr_1_i   : req_addr_0_i;
    assign sel_wdata_s  = gnt_port_s ? req_wdata_1_i  : req_wdata_0_i;

    // Transaction FSM and response registers; rejected requests skip ACCESS entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        port_q   <= gnt_port_s;
                        last_q   <= gnt_port_s;
                        write_q  <= sel_write_s;
                        funct3_q <= sel_funct3_s;
                        addr_q   <= sel_addr_s;
                        wdata_q  <= sel_wdata_s;
                        if (access_illegal(sel_write_s, sel_funct3_s, sel_addr_s)) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0000_0000;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= write_q ? 32'h0000_0000 : mem_rdata_i;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset drops them at once.
    assign mem_read_o   = (state_q == ST_ACCESS) & ~write_q;
    assign mem_write_o  = (state_q == ST_ACCESS) &  write_q;
    assign mem_funct3_o = (state_q == ST_ACCESS) ? funct3_q : 3'b000;
    assign mem_addr_o   = (state_q == ST_ACCESS) ? addr_q   : 32'h0000_0000;
    assign mem_wdata_o  = (state_q == ST_ACCESS) ? wdata_q  : 32'h0000_0000;

    assign rsp_valid_o  = (state_q == ST_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rdata_o  = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (alignment check on/off) share the request inputs,
// each backed by its own byte-array data memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [2:0]  req_funct3_0, req_funct3_1;
    logic [31:0] req_addr_0, req_addr_1, req_wdata_0, req_wdata_1;

    logic [1:0]  ready_a, rsp_valid_a, ready_b, rsp_valid_b;
    logic        err_a, err_b, mem_read_a, mem_read_b, mem_write_a, mem_write_b;
    logic [31:0] rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b, mrdata_a, mrdata_b;
    logic [2:0]  mf3_a, mf3_b;

    logic [7:0]  mem_a [0:4095];
    logic [7:0]  mem_b [0:4095];
    int          wr_cnt_a;
    int          n_checks;
    int          n_fail;

    dmem_arbiter #(.MEM_BYTES(4096), .CHECK_ALIGN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_a),
        .req_write_i(req_write), .req_funct3_0_i(req_funct3_0), .req_funct3_1_i(req_funct3_1),
        .req_addr_0_i(req_addr_0), .req_addr_1_i(req_addr_1),
        .req_wdata_0_i(req_wdata_0), .req_wdata_1_i(req_wdata_1),
        .rsp_valid_o(rsp_valid_a), .rsp_err_o(err_a), .rsp_rdata_o(rdata_a),
        .mem_read_o(mem_read_a), .mem_write_o(mem_write_a), .mem_funct3_o(mf3_a),
        .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a));

    dmem_arbiter #(.MEM_BYTES(4096), .CHECK_ALIGN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_b),
        .req_write_i(req_write), .req_funct3_0_i(req_funct3_0), .req_funct3_1_i(req_funct3_1),
        .req_addr_0_i(req_addr_0), .req_addr_1_i(req_addr_1),
        .req_wdata_0_i(req_wdata_0), .req_wdata_1_i(req_wdata_1),
        .rsp_valid_o(rsp_valid_b), .rsp_err_o(err_b), .rsp_rdata_o(rdata_b),
        .mem_read_o(mem_read_b), .mem_write_o(mem_write_b), .mem_funct3_o(mf3_b),
        .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memrd(input logic [7:0] b0, b1, b2, b3, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'h000000, b0};
            3'b101:  return {16'h0000, b1, b0};
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [11:0] ia0, ia1, ia2, ia3, ib0, ib1, ib2, ib3;
    assign ia0 = maddr_a[11:0];
    assign ia1 = ia0 + 12'd1;
    assign ia2 = ia0 + 12'd2;
    assign ia3 = ia0 + 12'd3;
    assign ib0 = maddr_b[11:0];
    assign ib1 = ib0 + 12'd1;
    assign ib2 = ib0 + 12'd2;
    assign ib3 = ib0 + 12'd3;
    assign mrdata_a = memrd(mem_a[ia0], mem_a[ia1], mem_a[ia2], mem_a[ia3], mf3_a);
    assign mrdata_b = memrd(mem_b[ib0], mem_b[ib1], mem_b[ib2], mem_b[ib3], mf3_b);

    // Data memory models: byte-lane stores commit on the rising edge.
    always @(posedge clk) begin
        if (mem_write_a) begin
            mem_a[ia0] <= mwdata_a[7:0];
            if (mf3_a[1:0] != 2'b00) mem_a[ia1] <= mwdata_a[15:8];
            if (mf3_a[1:0] == 2'b10) begin
                mem_a[ia2] <= mwdata_a[23:16];
                mem_a[ia3] <= mwdata_a[31:24];
            end
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (mem_write_b) begin
            mem_b[ib0] <= mwdata_b[7:0];
            if (mf3_b[1:0] != 2'b00) mem_b[ib1] <= mwdata_b[15:8];
            if (mf3_b[1:0] == 2'b10) begin
                mem_b[ib2] <= mwdata_b[23:16];
                mem_b[ib3] <= mwdata_b[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request on one port; waits for grant then response, observing instance inst.
    task automatic xfer(input string tag, input int inst, input int port, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        logic [1:0] rdy, rsp, onehot;
        logic       got;
        int         lat;
        onehot = (port == 1) ? 2'b10 : 2'b01;
        if (port == 1) begin
            req_write[1] = wr; req_funct3_1 = f3; req_addr_1 = addr; req_wdata_1 = wdata;
        end else begin
            req_write[0] = wr; req_funct3_0 = f3; req_addr_0 = addr; req_wdata_0 = wdata;
        end
        req_valid = onehot;
        #1;
        got = 1'b0;
        lat = 99;
        for (int k = 0; k < 20 && !got; k++) begin
            rdy = (inst == 1) ? ready_b : ready_a;
            if ((rdy & onehot) != 2'b00) got = 1'b1;
            else begin
                @(negedge clk); #1;
            end
        end
        if (got) begin
            @(posedge clk);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk); #1;
                req_valid = 2'b00;
                rsp = (inst == 1) ? rsp_valid_b : rsp_valid_a;
                if (rsp != 2'b00) begin
                    lat = k;
                    check({tag, "_port"}, 32'(rsp), 32'(onehot));
                    check({tag, "_err"}, 32'((inst == 1) ? err_b : err_a), 32'(exp_err));
                    check({tag, "_rdata"}, (inst == 1) ? rdata_b : rdata_a, exp_rdata);
                    break;
                end
            end
        end
        req_valid = 2'b00;
        check({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wr_before;
        logic [1:0] exp_rdy, exp_rsp;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[12'h014 + i] = 8'h11 * 8'(i + 1);
            mem_b[12'h014 + i] = 8'h11 * 8'(i + 1);
            mem_a[12'h040 + i] = 8'h55 + 8'h11 * 8'(i);
            mem_b[12'h040 + i] = 8'h55 + 8'h11 * 8'(i);
        end
        rst_n = 1'b0;
        req_valid = 2'b00; req_write = 2'b00;
        req_funct3_0 = 3'b000; req_funct3_1 = 3'b000;
        req_addr_0 = 32'h0; req_addr_1 = 32'h0; req_wdata_0 = 32'h0; req_wdata_1 = 32'h0;

        // Reset values, then a quiet idle stretch
        @(negedge clk); #1;
        check("rst_outputs", {25'd0, ready_a, rsp_valid_a, err_a, mem_read_a, mem_write_a},
              32'h0000_0000);
        check("rst_rdata", rdata_a, 32'h0000_0000);
        check("rst_mem_bus", maddr_a | mwdata_a | 32'(mf3_a), 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("idle_no_mem", {30'd0, mem_read_a, mem_write_a}, 32'h0);
        end

        // Basic store/load with sign and zero extension
        xfer("sw_10", 0, 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer("lw_10", 0, 0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        xfer("lb_13", 0, 0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE);
        xfer("lbu_13", 0, 0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE);
        xfer("lhu_p1", 0, 1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD);

        // Both ports requesting continuously from reset: strict alternation every 3 cycles
        do_reset();
        req_write    = 2'b00;
        req_funct3_0 = 3'b010; req_addr_0 = 32'h10;
        req_funct3_1 = 3'b010; req_addr_1 = 32'h40;
        req_valid    = 2'b11;
        #1;
        for (int k = 0; k < 12; k++) begin
            exp_rdy = ((k % 3) == 0) ? ((((k / 3) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = ((k % 3) == 2) ? ((((k / 3) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            check("rr_ready", 32'(ready_a), 32'(exp_rdy));
            check("rr_rsp", 32'(rsp_valid_a), 32'(exp_rsp));
            if ((k % 3) == 2) begin
                check("rr_rdata", rdata_a, (((k / 3) % 2) == 0) ? 32'hDEADBEEF : 32'h88776655);
            end
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;

        // Alignment check disabled: misaligned word load goes through
        xfer("noalign_lw_12", 1, 0, 1'b0, 3'b010, 32'h12, 32'h0, 1'b0, 32'h2211DEAD);

        // Illegal accesses are screened and never write
        wr_before = wr_cnt_a;
        xfer("err_lw_12", 0, 0, 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0);
        xfer("err_sh_11", 0, 0, 1'b1, 3'b001, 32'h11, 32'h0000CAFE, 1'b1, 32'h0);
        xfer("err_sw_1000", 0, 1, 1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("err_st_f3_100", 0, 0, 1'b1, 3'b100, 32'h10, 32'h01234567, 1'b1, 32'h0);
        xfer("err_ld_f3_011", 0, 0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
        check("err_no_writes", 32'(wr_cnt_a - wr_before), 32'd0);
        xfer("err_readback_10", 0, 0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        xfer("err_readback_0", 0, 0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset during the ACCESS cycle of a store: lost, no response, arbitration restarts
        xfer("sw_20_prior", 0, 0, 1'b1, 3'b010, 32'h20, 32'h11111111, 1'b0, 32'h0);
        req_write[0] = 1'b1; req_funct3_0 = 3'b010; req_addr_0 = 32'h20; req_wdata_0 = 32'h12345678;
        req_valid = 2'b01;
        #1;
        check("rst_mid_ready", 32'(ready_a), 32'(2'b01));
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = 2'b00;
        check("rst_mid_write_on", 32'(mem_write_a), 32'd1);
        check("rst_mid_addr", maddr_a, 32'h20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_write_drop", {30'd0, mem_read_a, mem_write_a}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check("rst_mid_no_rsp", 32'(rsp_valid_a), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_write = 2'b00;
        req_funct3_0 = 3'b010; req_addr_0 = 32'h20;
        req_funct3_1 = 3'b010; req_addr_1 = 32'h40;
        req_valid = 2'b11;
        #1;
        check("rst_restart_port0", 32'(ready_a), 32'(2'b01));
        xfer("lw_20_after_rst", 0, 0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
